// File: rtl/data_mem_slave.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO window
// holding a UART transmitter with TX FIFO, a status register and a cycle counter.
module data_mem_slave #(
  parameter int unsigned DEPTH        = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]   RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [FW:0]   FIFO_FULL = (FW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  localparam logic [9:0] REG_TXDATA = 10'd0;
  localparam logic [9:0] REG_STATUS = 10'd1;
  localparam logic [9:0] REG_CYCLE  = 10'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  logic           mmio_sel;
  logic           ram_sel;
  logic           wr_en;
  logic [9:0]     reg_idx;
  logic [AW-1:0]  ram_idx;
  logic           txdata_wr;
  logic           status_wr;
  logic           cycle_wr;

  logic [31:0]    mem [DEPTH];
  logic [31:0]    cycle_cnt;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]  rd_ptr;
  logic [FW-1:0]  wr_ptr;
  logic [FW:0]    count;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push_ok;
  logic           pop;
  logic           ovf;

  tx_state_t      state;
  tx_state_t      state_next;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  timer_next;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_idx_next;
  logic [7:0]     shift;
  logic [7:0]     shift_next;
  logic           tx_q;
  logic           tx_next;
  logic           busy;

  // MMIO takes precedence so a window placed inside the RAM range still decodes.
  assign mmio_sel  = (addr_i[31:12] == MMIO_BASE[31:12]);
  assign ram_sel   = !mmio_sel && (addr_i < RAM_BYTES);
  assign wr_en     = ce_i && we_i && !rst;
  assign reg_idx   = addr_i[11:2];
  assign ram_idx   = addr_i[AW+1:2];
  assign txdata_wr = wr_en && mmio_sel && (reg_idx == REG_TXDATA);
  assign status_wr = wr_en && mmio_sel && (reg_idx == REG_STATUS);
  assign cycle_wr  = wr_en && mmio_sel && (reg_idx == REG_CYCLE);

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) begin
      mem[ram_idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cycle_wr) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL);
  // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = txdata_wr && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (txdata_wr && !push_ok) begin
        ovf <= 1'b1;
      end else if (status_wr && wdata_i[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx_q    <= tx_next;
    end
  end

  // tx_next is the line level for the cycle that follows this edge.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    tx_next      = tx_q;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          timer_next = BIT_LAST;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (timer == '0) begin
          state_next   = DATA;
          timer_next   = BIT_LAST;
          bit_idx_next = 3'd0;
          tx_next      = shift[0];
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_next = BIT_LAST;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (timer == '0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign tx_o = tx_q;

  always_comb begin
    rdata_o = '0;
    if (ce_i && !rst) begin
      if (mmio_sel) begin
        case (reg_idx)
          REG_STATUS: rdata_o = {28'b0, ovf, busy, fifo_full, fifo_empty};
          REG_CYCLE:  rdata_o = cycle_cnt;
          default:    rdata_o = '0;
        endcase
      end else if (ram_sel) begin
        rdata_o = mem[ram_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed bench for data_mem_slave: RAM, CYCLE, STATUS checks plus a UART
// receiver that pops expected bytes from a scoreboard queue as frames arrive.
module tb_data_mem_slave;

  localparam int CPB = 4;
  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0004;
  localparam logic [31:0] CYCLE  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  data_mem_slave #(
    .DEPTH(16),
    .MMIO_BASE(32'h8000_0000),
    .FIFO_DEPTH(4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce_i(ce),
    .we_i(we),
    .addr_i(addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .tx_o(tx)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = c;
    we = w;
    addr = a;
    wdata = d;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    apply_stimulus(1'b1, 1'b0, a, 32'h0);
    #1;
    check_output(tag, rdata, exp);
  endtask

  // UART receiver: samples mid-bit one step after each rising edge; reset aborts
  // any frame in flight and drops queued expectations, as the DUT empties its FIFO.
  initial begin
    logic       rx_active;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    rx_active = 1'b0;
    rx_cnt = 0;
    rx_byte = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rx_active = 1'b0;
        exp_q.delete();
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == CPB / 2) begin
          check_output("rx_start", {31'b0, tx}, 32'h0);
        end else if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB &&
                     (rx_cnt - CPB / 2) % CPB == 0) begin
          rx_byte[(rx_cnt - CPB - CPB / 2) / CPB] = tx;
        end else if (rx_cnt == 9 * CPB + CPB / 2) begin
          check_output("rx_stop", {31'b0, tx}, 32'h1);
          check_output("rx_queue_nonempty", {31'b0, exp_q.size() != 0}, 32'h1);
          if (exp_q.size() != 0) begin
            exp_byte = exp_q.pop_front();
            check_output("rx_byte", {24'b0, rx_byte}, {24'b0, exp_byte});
          end
          rx_active = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] frame;
    logic       exp_bit;
    logic       saw_low;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    ce = 1'b1;
    addr = STATUS;
    #1;
    check_output("rdata_in_reset", rdata, 32'h0);
    check_output("tx_in_reset", {31'b0, tx}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b0;

    $display("[TB] RAM");
    apply_stimulus(1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111);
    apply_stimulus(1'b1, 1'b1, 32'h0000_003C, 32'hDEAD_BEEF);
    read_check("ram_3c", 32'h0000_003C, 32'hDEAD_BEEF);
    read_check("unmapped_40", 32'h0000_0040, 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    read_check("ram_3c_after_unmapped", 32'h0000_003C, 32'hDEAD_BEEF);
    read_check("ram_0_no_alias", 32'h0000_0000, 32'h1111_1111);
    read_check("status_idle", STATUS, 32'h1);

    $display("[TB] ce low");
    apply_stimulus(1'b0, 1'b1, 32'h0000_003C, 32'hCAFE_F00D);
    #1;
    check_output("ce0_ram_rdata", rdata, 32'h0);
    apply_stimulus(1'b0, 1'b1, TXDATA, 32'h0000_00AA);
    #1;
    check_output("ce0_tx_rdata", rdata, 32'h0);
    read_check("ce0_ram_unchanged", 32'h0000_003C, 32'hDEAD_BEEF);
    read_check("ce0_no_push", STATUS, 32'h1);

    $display("[TB] CYCLE");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b1;
    we = 1'b0;
    addr = CYCLE;
    #1;
    check_output("cycle_after_reset", rdata, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check_output("cycle_10", rdata, 32'd10);
    apply_stimulus(1'b1, 1'b1, CYCLE, 32'h0000_1234);
    read_check("cycle_cleared", CYCLE, 32'd0);
    read_check("cycle_after_clear", CYCLE, 32'd1);
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    release dut.cycle_cnt;
    #1;
    check_output("cycle_forced", rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    check_output("cycle_wrap", rdata, 32'd0);

    $display("[TB] UART frame 0x55");
    frame = 8'h55;
    apply_stimulus(1'b1, 1'b1, TXDATA, {24'b0, frame});
    exp_q.push_back(frame);
    read_check("status_queued", STATUS, 32'h0);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      #1;
      if (k < CPB) exp_bit = 1'b0;
      else if (k < 9 * CPB) exp_bit = frame[(k - CPB) / CPB];
      else exp_bit = 1'b1;
      check_output($sformatf("frame_tx_%0d", k), {31'b0, tx}, {31'b0, exp_bit});
      check_output($sformatf("frame_busy_%0d", k), {31'b0, rdata[2]}, 32'h1);
    end
    @(negedge clk);
    #1;
    check_output("status_after_frame", rdata, 32'h1);

    $display("[TB] FIFO overflow");
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b1, 1'b1, TXDATA, i);
      if (i <= 5) exp_q.push_back(8'(i));
    end
    read_check("status_overflow", STATUS, 32'hE);
    apply_stimulus(1'b1, 1'b1, STATUS, 32'h8);
    read_check("status_ovf_cleared", STATUS, 32'h6);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (rdata === 32'h1 && exp_q.size() == 0) break;
    end
    check_output("drain_status", rdata, 32'h1);
    check_output("drain_queue", exp_q.size(), 32'd0);

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 1'b1, 32'h0000_0014, 32'h0BAD_F00D);
    apply_stimulus(1'b1, 1'b1, TXDATA, 32'hA1);
    exp_q.push_back(8'hA1);
    apply_stimulus(1'b1, 1'b1, TXDATA, 32'hA2);
    exp_q.push_back(8'hA2);
    apply_stimulus(1'b1, 1'b1, TXDATA, 32'hA3);
    exp_q.push_back(8'hA3);
    apply_stimulus(1'b1, 1'b0, STATUS, 32'h0);
    repeat (14) @(negedge clk);
    #1;
    check_output("midframe_bit2_low", {31'b0, tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("tx_high_after_reset", {31'b0, tx}, 32'h1);
    check_output("rdata_zero_in_reset", rdata, 32'h0);
    rst = 1'b0;
    #1;
    check_output("status_after_reset", rdata, 32'h1);
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check_output("no_frames_after_reset", {31'b0, saw_low}, 32'h0);
    read_check("ram_kept_over_reset", 32'h0000_0014, 32'h0BAD_F00D);
    read_check("ram_3c_kept", 32'h0000_003C, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
